// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// FSM state type and the access legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } lsu_state_e;

    // Returns 1 when a load/store is present but its size/sign encoding is
    // illegal or the byte address is not naturally aligned for its size.
    function automatic logic lsu_fault(input logic       rd,
                                       input logic       wr,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic bad;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = addr_lo[0];
            F3_W:    bad = (addr_lo != 2'b00);
            F3_BU:   bad = wr;
            F3_HU:   bad = wr | addr_lo[0];
            default: bad = 1'b1;
        endcase
        return (rd | wr) & bad;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a read word and sign- or
// zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted_s;

    // Shift the addressed lane down to bit 0, then extend by access type.
    always_comb begin
        shifted_s = rdata_i >> {off_i, 3'b000};
        case (funct3_i)
            F3_B:    data_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F3_BU:   data_o = {24'h000000, shifted_s[7:0]};
            F3_H:    data_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F3_HU:   data_o = {16'h0000, shifted_s[15:0]};
            default: data_o = shifted_s;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: issues one request per memory instruction,
// waits for the memory acknowledge (or a timeout), stalls the pipeline
// meanwhile and registers the extended load result for MEM/WB.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_MemRead_i,
    input  logic        ex_mem_MemWrite_i,
    input  logic [2:0]  ex_mem_funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] readMem_o,
    output logic        stall_o,
    output logic        fault_o,
    output logic        timeout_o
);

    // Counter value seen in the last BUSY cycle before giving up.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;
    logic [31:0]      rmem_q, rmem_d;
    logic             to_q, to_d;

    logic             access_s;
    logic             fault_s;
    logic [3:0]       st_be_s;
    logic [31:0]      st_wdata_s;
    logic [31:0]      load_ext_s;
    logic             stall_s;

    assign access_s = ex_mem_MemRead_i | ex_mem_MemWrite_i;
    assign fault_s  = lsu_fault(ex_mem_MemRead_i, ex_mem_MemWrite_i,
                                ex_mem_funct3_i, addr_i[1:0]);

    // Extension is applied to the latched size/offset so it is immune to
    // whatever the stalled pipeline presents on the inputs.
    lsu_load_align u_align (
        .rdata_i  (dmem_rdata_i),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .data_o   (load_ext_s)
    );

    // Byte enables and lane-replicated store data; loads request the whole word.
    always_comb begin
        case (ex_mem_funct3_i)
            F3_B: begin
                st_be_s    = 4'b0001 << addr_i[1:0];
                st_wdata_s = {4{wdata_i[7:0]}};
            end
            F3_H: begin
                st_be_s    = 4'b0011 << addr_i[1:0];
                st_wdata_s = {2{wdata_i[15:0]}};
            end
            default: begin
                st_be_s    = 4'b1111;
                st_wdata_s = wdata_i;
            end
        endcase
        if (!ex_mem_MemWrite_i) begin
            st_be_s    = 4'b1111;
            st_wdata_s = 32'h0000_0000;
        end else begin
            st_be_s    = st_be_s;
            st_wdata_s = st_wdata_s;
        end
    end

    // Next-state logic: issue from IDLE, wait/timeout in BUSY, release in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rmem_d  = rmem_q;
        to_d    = 1'b0;
        stall_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (access_s && !fault_s) begin
                    stall_s = 1'b1;
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = ex_mem_MemWrite_i;
                    addr_d  = {addr_i[31:2], 2'b00};
                    be_d    = st_be_s;
                    wdata_d = st_wdata_s;
                    f3_d    = ex_mem_funct3_i;
                    off_d   = addr_i[1:0];
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    stall_s = 1'b0;
                end
            end
            BUSY: begin
                stall_s = 1'b1;
                if (dmem_ack_i) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) begin
                        rmem_d = load_ext_s;
                    end else begin
                        rmem_d = rmem_q;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    rmem_d  = 32'h0000_0000;
                    to_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0000_0000;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0000_0000;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            rmem_q  <= 32'h0000_0000;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rmem_q  <= rmem_d;
            to_q    <= to_d;
        end
    end

    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;
    assign readMem_o    = rmem_q;
    assign timeout_o    = to_q;
    assign stall_o      = stall_s;
    assign fault_o      = fault_s;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed scenarios plus random
// accesses, checked against a behavioural model of the access rules.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_mem_MemRead_i, ex_mem_MemWrite_i;
    logic [2:0]  ex_mem_funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic [31:0] readMem_o;
    logic        stall_o, fault_o, timeout_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_rmem = 32'h0;

    lsu_mem_stage #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
        .clk               (clk),
        .rst               (rst),
        .ex_mem_MemRead_i  (ex_mem_MemRead_i),
        .ex_mem_MemWrite_i (ex_mem_MemWrite_i),
        .ex_mem_funct3_i   (ex_mem_funct3_i),
        .addr_i            (addr_i),
        .wdata_i           (wdata_i),
        .dmem_req_o        (dmem_req_o),
        .dmem_we_o         (dmem_we_o),
        .dmem_addr_o       (dmem_addr_o),
        .dmem_be_o         (dmem_be_o),
        .dmem_wdata_o      (dmem_wdata_o),
        .dmem_ack_i        (dmem_ack_i),
        .dmem_rdata_i      (dmem_rdata_i),
        .readMem_o         (readMem_o),
        .stall_o           (stall_o),
        .fault_o           (fault_o),
        .timeout_o         (timeout_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int unsigned m_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic m_fault(input logic rd, input logic wr, input logic [2:0] f3,
                                     input logic [31:0] a);
        logic illegal;
        if (!(rd || wr)) return 1'b0;
        illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (wr && f3 >= 3'd4);
        return illegal || ((a % m_size(f3)) != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        int unsigned off;
        logic [31:0] v;
        off = a % 4;
        if (f3 == 3'd2) return rd;
        if (m_size(f3) == 1) v = (rd >> (8 * off)) & 32'd255;
        else                 v = (rd >> (8 * off)) & 32'd65535;
        if (f3 == 3'd0 && v >= 32'd128)   v = v - 32'd256;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        int unsigned mask;
        if (!wr) return 4'hF;
        mask = ((1 << m_size(f3)) - 1) << (a % 4);
        return 4'(mask);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (m_size(f3) == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (m_size(f3) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    // One instruction in MEM: ack_at is the BUSY cycle (1-based) carrying the
    // ack, 0 means the memory never answers. Starts and ends #1 after an edge.
    task automatic run_access(input string nm, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rdat,
                              input int ack_at);
        logic        ef;
        logic        timed_out;
        logic [31:0] ea;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        ex_mem_MemRead_i  = rd;
        ex_mem_MemWrite_i = wr;
        ex_mem_funct3_i   = f3;
        addr_i            = a;
        wdata_i           = wd;
        dmem_ack_i        = 1'b0;
        dmem_rdata_i      = $urandom;
        ef  = m_fault(rd, wr, f3, a);
        ea  = a & 32'hFFFF_FFFC;
        ebe = m_be(wr, f3, a);
        ewd = m_wdata(f3, wd);
        #1;
        n_vec++;
        if (fault_o !== ef) begin
            n_err++;
            $display("FAIL %s fault_o: got %b expected %b", nm, fault_o, ef);
        end
        n_vec++;
        if (stall_o !== ((rd | wr) & ~ef)) begin
            n_err++;
            $display("FAIL %s idle stall_o: got %b expected %b", nm, stall_o, (rd | wr) & ~ef);
        end
        if (!(rd || wr) || ef) begin
            @(posedge clk); #1;
            n_vec++;
            if (dmem_req_o !== 1'b0 || readMem_o !== exp_rmem) begin
                n_err++;
                $display("FAIL %s no-issue: req %b rmem %h expected req 0 rmem %h",
                         nm, dmem_req_o, readMem_o, exp_rmem);
            end
            ex_mem_MemRead_i  = 1'b0;
            ex_mem_MemWrite_i = 1'b0;
            return;
        end
        @(posedge clk); #1;
        timed_out = 1'b1;
        for (int cyc = 1; cyc <= 64; cyc++) begin
            n_vec++;
            if (dmem_req_o !== 1'b1 || stall_o !== 1'b1 || dmem_we_o !== wr ||
                dmem_addr_o !== ea || dmem_be_o !== ebe || (wr && dmem_wdata_o !== ewd)) begin
                n_err++;
                $display("FAIL %s busy cyc %0d: req %b stall %b we %b addr %h be %b wd %h expected 1 1 %b %h %b %h",
                         nm, cyc, dmem_req_o, stall_o, dmem_we_o, dmem_addr_o, dmem_be_o,
                         dmem_wdata_o, wr, ea, ebe, ewd);
            end
            dmem_ack_i   = (cyc == ack_at);
            dmem_rdata_i = (cyc == ack_at) ? rdat : $urandom;
            addr_i       = $urandom;
            wdata_i      = $urandom;
            @(posedge clk); #1;
            if (cyc == ack_at) begin
                timed_out = 1'b0;
                break;
            end
        end
        if (timed_out) exp_rmem = 32'h0;
        else if (!wr)  exp_rmem = m_load(f3, a, rdat);
        dmem_ack_i = 1'b0;
        n_vec++;
        if (dmem_req_o !== 1'b0 || stall_o !== 1'b0 || timeout_o !== timed_out ||
            readMem_o !== exp_rmem) begin
            n_err++;
            $display("FAIL %s done: req %b stall %b timeout %b rmem %h expected 0 0 %b %h",
                     nm, dmem_req_o, stall_o, timeout_o, readMem_o, timed_out, exp_rmem);
        end
        ex_mem_MemRead_i  = 1'b0;
        ex_mem_MemWrite_i = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (timeout_o !== 1'b0 || dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s back-idle: timeout %b req %b stall %b expected 0 0 0",
                     nm, timeout_o, dmem_req_o, stall_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ex_mem_MemRead_i = 1'b0; ex_mem_MemWrite_i = 1'b0; ex_mem_funct3_i = 3'd0;
        addr_i = 32'h0; wdata_i = 32'h0; dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
        #12;
        n_vec++;
        if (dmem_req_o !== 1'b0 || dmem_we_o !== 1'b0 || dmem_addr_o !== 32'h0 ||
            dmem_be_o !== 4'h0 || dmem_wdata_o !== 32'h0 || readMem_o !== 32'h0 ||
            timeout_o !== 1'b0 || stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset: req %b we %b addr %h be %b wd %h rmem %h to %b stall %b expected all 0",
                     dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
                     readMem_o, timeout_o, stall_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        exp_rmem = 32'h0;
    endtask

    task automatic test_lw();
        run_access("lw", 1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 2);
    endtask

    task automatic test_lb_lbu_lh();
        run_access("lb",  1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_FF7F, 1);
        run_access("lbu", 1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_FF7F, 3);
        run_access("lh",  1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 32'h80FF_FF7F, 1);
        run_access("lhu", 1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 32'h80FF_FF7F, 2);
    endtask

    task automatic test_stores();
        run_access("sb", 1'b0, 1'b1, 3'd0, 32'h201, 32'h1234_5678, 32'h0, 1);
        run_access("sh", 1'b0, 1'b1, 3'd1, 32'h202, 32'h1234_5678, 32'h0, 2);
        run_access("sw", 1'b0, 1'b1, 3'd2, 32'h204, 32'hCAFE_F00D, 32'h0, 1);
    endtask

    task automatic test_faults();
        run_access("lh_mis",  1'b1, 1'b0, 3'd1, 32'h101, 32'h0, 32'h0, 1);
        run_access("sw_mis",  1'b0, 1'b1, 3'd2, 32'h102, 32'h0, 32'h0, 1);
        run_access("f3_011",  1'b1, 1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 1);
        run_access("sbu_ill", 1'b0, 1'b1, 3'd4, 32'h100, 32'h0, 32'h0, 1);
        run_access("nop",     1'b0, 1'b0, 3'd2, 32'h103, 32'h0, 32'h0, 1);
    endtask

    task automatic test_timeout();
        run_access("ld_ok",     1'b1, 1'b0, 3'd2, 32'h300, 32'h0, 32'h1111_2222, 1);
        run_access("timeout",   1'b1, 1'b0, 3'd2, 32'h300, 32'h0, 32'h5555_AAAA, 0);
        run_access("ack_at_64", 1'b1, 1'b0, 3'd2, 32'h304, 32'h0, 32'h7777_8888, 64);
    endtask

    task automatic test_reset_mid_busy();
        ex_mem_MemRead_i = 1'b1; ex_mem_MemWrite_i = 1'b0;
        ex_mem_funct3_i = 3'd2; addr_i = 32'h400; dmem_ack_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (dmem_req_o !== 1'b0 || dmem_addr_o !== 32'h0 || dmem_be_o !== 4'h0 ||
            readMem_o !== 32'h0 || timeout_o !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: req %b addr %h be %b rmem %h to %b expected all 0",
                     dmem_req_o, dmem_addr_o, dmem_be_o, readMem_o, timeout_o);
        end
        ex_mem_MemRead_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rmem = 32'h0;
        @(posedge clk); #1;
        n_vec++;
        if (timeout_o !== 1'b0 || dmem_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_after: to %b req %b expected 0 0", timeout_o, dmem_req_o);
        end
        run_access("after_rst", 1'b1, 1'b0, 3'd1, 32'h402, 32'h0, 32'h1234_ABCD, 2);
    endtask

    task automatic test_random();
        int unsigned kind;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            a    = $urandom;
            run_access("rand", kind >= 1 && kind <= 5, kind > 5,
                       3'($urandom_range(0, 7)), a, $urandom, $urandom,
                       int'($urandom_range(1, 4)));
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu_lh();
        test_stores();
        test_faults();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
